// File: rtl/stream_collector.sv
// Collects SIZE words from a valid/ready stream into a small buffer with registered readback.
// Optional running XOR checksum of each run is enabled by defining COLLECTOR_CHECKSUM_EN.
module stream_collector #(
  parameter int    SIZE  = 3,
  parameter int    WIDTH = 8,
  parameter string BURST = "yes"
) (
  input  logic                     iCLK,
  input  logic                     iRST,
  input  logic                     iStart,
  input  logic                     iValid_AM,
  output logic                     oReady_AM,
  input  logic [WIDTH-1:0]         iData_AM,
  output logic                     oEnd,
  output logic [$clog2(SIZE):0]    oCount,
  input  logic [$clog2(SIZE):0]    iRdAddr,
  output logic [WIDTH-1:0]         oRdData,
  output logic [WIDTH-1:0]         oChecksum
);

  localparam int CW    = $clog2(SIZE) + 1;
  localparam int AW    = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int DEPTH = 1 << AW;
  localparam bit THROTTLE = (BURST == "no");
  localparam logic [CW-1:0] SIZE_C = CW'(SIZE);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             xfer;
  logic             last;
  logic             start_run;

  assign xfer      = (state == COLLECT) && iValid_AM && oReady_AM;
  assign last      = (oCount == SIZE_C - CW'(1));
  assign start_run = ((state == IDLE) || (state == DONE)) && iStart;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state     <= IDLE;
      oReady_AM <= 1'b0;
      oEnd      <= 1'b0;
      oCount    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_run) begin
            state     <= COLLECT;
            oReady_AM <= 1'b1;
            oEnd      <= 1'b0;
            oCount    <= '0;
          end
        end
        COLLECT: begin
          if (xfer && last) begin
            state     <= DONE;
            oReady_AM <= 1'b0;
            oEnd      <= 1'b1;
            oCount    <= oCount + CW'(1);
          end else begin
            // throttled mode toggles every cycle, independent of upstream valid
            oReady_AM <= THROTTLE ? ~oReady_AM : 1'b1;
            if (xfer) oCount <= oCount + CW'(1);
          end
        end
        default: begin
          state     <= IDLE;
          oReady_AM <= 1'b0;
          oEnd      <= 1'b0;
        end
      endcase
    end
  end

  // storage is not reset and survives across runs
  always_ff @(posedge iCLK) begin
    if (xfer) mem[oCount[AW-1:0]] <= iData_AM;
  end

  always_ff @(posedge iCLK) begin
    if (iRST)
      oRdData <= '0;
    else if (iRdAddr < SIZE_C)
      oRdData <= mem[iRdAddr[AW-1:0]];
    else
      oRdData <= '0;
  end

`ifdef COLLECTOR_CHECKSUM_EN
  always_ff @(posedge iCLK) begin
    if (iRST)
      oChecksum <= '0;
    else if (start_run)
      oChecksum <= '0;
    else if (xfer)
      oChecksum <= oChecksum ^ iData_AM;
  end
`else
  assign oChecksum = '0;
`endif

endmodule

// File: doc/stream_collector.md
STREAM_COLLECTOR -- requirements
Module: stream_collector

Interface
REQ-001 The block SHALL have parameter SIZE, default 3, number of words collected per run (SIZE >= 1).
REQ-002 The block SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-003 The block SHALL have parameter BURST, default "yes"; "yes" holds ready high continuously, "no" throttles ready.
REQ-004 The block SHALL have port iCLK, input, 1, single clock; all logic on rising edge.
REQ-005 The block SHALL have port iRST, input, 1, reset, synchronous and active-high.
REQ-006 The block SHALL have port iStart, input, 1, level/pulse sampled each cycle to begin a run.
REQ-007 The block SHALL have port iValid_AM, input, 1, upstream word valid.
REQ-008 The block SHALL have port oReady_AM, output, 1, collector ready to accept.
REQ-009 The block SHALL have port iData_AM, input, WIDTH, upstream word.
REQ-010 The block SHALL have port oEnd, output, 1, high while SIZE words have been captured.
REQ-011 The block SHALL have port oCount, output, $clog2(SIZE)+1, number of words captured this run.
REQ-012 The block SHALL have port iRdAddr, input, $clog2(SIZE)+1, readback address.
REQ-013 The block SHALL have port oRdData, output, WIDTH, registered readback data.
REQ-014 The block SHALL have port oChecksum, output, WIDTH, XOR of words captured this run.

Function
REQ-015 The FSM SHALL have states IDLE, COLLECT, DONE.
REQ-016 In IDLE, oReady_AM SHALL be 0; iStart=1 SHALL move the FSM to COLLECT on the next edge, clearing oCount, the write pointer and oChecksum.
REQ-017 In COLLECT, a transfer SHALL occur exactly on a cycle with iValid_AM=1 and oReady_AM=1; the word SHALL be stored at address oCount, and oCount SHALL increment on that edge.
REQ-018 With BURST="yes", oReady_AM SHALL be 1 on every COLLECT cycle; with BURST="no", it SHALL be 1 on the first COLLECT cycle and alternate 0/1 thereafter, toggling every cycle regardless of iValid_AM.
REQ-019 oReady_AM SHALL be a registered output with no combinational path from iValid_AM.
REQ-020 The transfer that makes oCount equal SIZE SHALL move the FSM to DONE on the same edge; oReady_AM SHALL be 0 in DONE, so no transfer beyond SIZE occurs.
REQ-021 In DONE, oEnd SHALL be 1; oEnd SHALL be 0 in all other states.
REQ-022 iStart=1 in DONE SHALL start a new run, as in REQ-016.
REQ-023 iStart in COLLECT SHALL be ignored.
REQ-024 oRdData SHALL equal the stored word at iRdAddr one cycle after iRdAddr is sampled, in any state.
REQ-025 For iRdAddr >= SIZE, oRdData SHALL be 0.
REQ-026 A read and a write to the same address on the same cycle SHALL return the old contents.
REQ-027 Storage SHALL retain contents across runs until overwritten, and SHALL not be cleared by iStart.

Reset
REQ-028 While iRST=1, the FSM SHALL enter IDLE and oReady_AM, oEnd, oCount, oRdData and oChecksum SHALL be 0 on the next edge.
REQ-029 Storage contents SHALL be undefined after reset.
REQ-030 Reset asserted mid-COLLECT SHALL abort the run; no transfer SHALL be counted on that edge.
REQ-031 Reset SHALL take priority over iStart.

Configuration
REQ-032 With macro COLLECTOR_CHECKSUM_EN defined, oChecksum SHALL update on each transfer to oChecksum XOR iData_AM, be cleared at run start, and hold in DONE.
REQ-033 Without COLLECTOR_CHECKSUM_EN, oChecksum SHALL be constant 0 and no checksum register SHALL be synthesized.

Verification
REQ-034 SIZE=3, WIDTH=8, BURST="yes"; reset, pulse iStart, send 0x11, 0x22, 0x33 back-to-back -> oReady_AM high 3 cycles; oEnd=1 the cycle after the third transfer; oCount=3; oChecksum=0x00 with macro.
REQ-035 BURST="no", valid held high with 0xA5, 0x5A, 0xFF -> ready pattern 1,0,1,0,1; transfers at ready=1 only; completion after 5 COLLECT cycles; oChecksum=0x00.
REQ-036 After REQ-034, iRdAddr=0,1,2,3 on consecutive cycles -> oRdData = 0x11, 0x22, 0x33, 0x00, each lagging by one cycle.
REQ-037 Assert iRST after 2 transfers -> next edge oCount=0, oReady_AM=0, FSM in IDLE; a new iStart then completes a full 3-word run.
REQ-038 In DONE, hold iValid_AM=1 with 0x77 -> no transfer, oCount stays 3; iStart pulse -> oEnd=0, oCount=0, and 0x77 is captured at address 0.
REQ-039 Build without COLLECTOR_CHECKSUM_EN, run REQ-034 stimulus -> oChecksum=0 throughout.
